// File: rtl/mcu_io_ctrl.sv
// -----------------------------------------------------------------------------
// mcu_io_ctrl
//   Memory-mapped I/O controller for the MCU core. One register bus gives the
//   core access to a synchronised switch input, a buffered keypad FIFO and
//   OUT_CH output channels (ch0 = LSB display, ch1 = MSB display).
//
// Ports
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous, active-low reset
//   in         in   DATA_W          switch input, asynchronous to clk
//   KB         in   DATA_W          keypad code, stable while kb_strobe high
//   kb_strobe  in   1               keypad strobe, asynchronous; key = rising edge
//   io_addr    in   ADDR_W          register address
//   io_wr      in   1               write enable, one cycle per write
//   io_wdata   in   DATA_W          write data
//   io_rd      in   1               read enable, one cycle per read
//   io_rdata   out  DATA_W          registered read data
//   out_bus    out  OUT_CH*DATA_W   output channels, ch k at [k*DATA_W +: DATA_W]
//   kb_irq     out  1               high while the keypad FIFO is non-empty
//
// Register map
//   0x0     R    IN     synchronised switch value
//   0x1     R    KBDAT  FIFO head, read pops; empty FIFO reads 0 without a pop
//   0x2     R/W  STAT   R: {overflow, 0.., count}; W: io_wdata[MSB]=1 clears overflow
//   0x4+k   R/W  OUTk   output channel k
//   others  read 0, writes ignored
//
// Bus semantics: there is no handshake. A strobe (io_rd or io_wr) high on a
// rising edge is one complete access. A read loads io_rdata on that edge and
// the value is held until the next read. A read and a write in the same cycle
// are both performed; the read sees the value from before the write.
// -----------------------------------------------------------------------------
module mcu_io_ctrl #(
  parameter int DATA_W   = 8,
  parameter int OUT_CH   = 2,
  parameter int KB_DEPTH = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in,
  input  logic [DATA_W-1:0]        KB,
  input  logic                     kb_strobe,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic                     io_wr,
  input  logic [DATA_W-1:0]        io_wdata,
  input  logic                     io_rd,
  output logic [DATA_W-1:0]        io_rdata,
  output logic [OUT_CH*DATA_W-1:0] out_bus,
  output logic                     kb_irq
);

  localparam int PTR_W = $clog2(KB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_KBDAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(2);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(KB_DEPTH);

  // Synchronisers: two flops on each async input, a third on the strobe so a
  // key is counted once, on the first cycle the synchronised strobe is high.
  logic [DATA_W-1:0] r_in_s1, r_in_s2;
  logic              r_stb_s1, r_stb_s2, r_stb_s3;

  // Keypad FIFO
  logic [DATA_W-1:0] r_fifo [KB_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  // Output channels
  logic [OUT_CH-1:0][DATA_W-1:0] r_out;

  logic              w_key_evt;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_stat;
  logic [DATA_W-1:0] w_rdata;

  assign w_key_evt = r_stb_s2 & ~r_stb_s3;
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pop     = io_rd && (io_addr == A_KBDAT) && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the key.
  assign w_push    = w_key_evt && (!w_full || w_pop);
  assign w_ovf_set = w_key_evt && w_full && !w_pop;
  assign w_ovf_clr = io_wr && (io_addr == A_STAT) && io_wdata[DATA_W-1];

  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_head = w_empty ? '0 : r_fifo[r_rd_ptr];

  always_comb begin
    w_stat                = '0;
    w_stat[CNT_W-1:0]     = r_count;
    w_stat[DATA_W-1]      = r_overflow;
  end

  // Read mux from current (pre-write) register values.
  always_comb begin
    w_rdata = '0;
    if (io_addr == A_IN)         w_rdata = r_in_s2;
    else if (io_addr == A_KBDAT) w_rdata = w_head;
    else if (io_addr == A_STAT)  w_rdata = w_stat;
    for (int k = 0; k < OUT_CH; k++) begin
      if (io_addr == ADDR_W'(4 + k)) w_rdata = r_out[k];
    end
  end

  // Input synchronisers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_s1  <= '0;
      r_in_s2  <= '0;
      r_stb_s1 <= 1'b0;
      r_stb_s2 <= 1'b0;
      r_stb_s3 <= 1'b0;
    end else begin
      r_in_s1  <= in;
      r_in_s2  <= r_in_s1;
      r_stb_s1 <= kb_strobe;
      r_stb_s2 <= r_stb_s1;
      r_stb_s3 <= r_stb_s2;
    end
  end

  // FIFO storage carries no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= KB;
  end

  // FIFO control, overflow flag and interrupt. Pointers wrap naturally since
  // KB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      kb_irq     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      kb_irq  <= (w_count_next != '0);
      // A dropped key in the same cycle as a clear leaves the flag set.
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  // Output channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else if (io_wr) begin
      for (int k = 0; k < OUT_CH; k++) begin
        if (io_addr == ADDR_W'(4 + k)) r_out[k] <= io_wdata;
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_rdata <= '0;
    end else if (io_rd) begin
      io_rdata <= w_rdata;
    end
  end

  assign out_bus = r_out;

endmodule

// File: tb/tb_mcu_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcu_io_ctrl
//   Self-checking bench for mcu_io_ctrl with default parameters. A reference
//   model (key queue, overflow flag, output channel array, last switch value)
//   predicts every read and every output, directed scenarios cover the corner
//   cases and a randomized loop mixes all register operations.
// -----------------------------------------------------------------------------
module tb_mcu_io_ctrl;

  localparam int DATA_W   = 8;
  localparam int OUT_CH   = 2;
  localparam int KB_DEPTH = 4;
  localparam int ADDR_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]        in        = '0;
  logic [DATA_W-1:0]        KB        = '0;
  logic                     kb_strobe = 1'b0;
  logic [ADDR_W-1:0]        io_addr   = '0;
  logic                     io_wr     = 1'b0;
  logic [DATA_W-1:0]        io_wdata  = '0;
  logic                     io_rd     = 1'b0;
  logic [DATA_W-1:0]        io_rdata;
  logic [OUT_CH*DATA_W-1:0] out_bus;
  logic                     kb_irq;

  mcu_io_ctrl #(
    .DATA_W(DATA_W), .OUT_CH(OUT_CH), .KB_DEPTH(KB_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .KB(KB), .kb_strobe(kb_strobe),
    .io_addr(io_addr), .io_wr(io_wr), .io_wdata(io_wdata), .io_rd(io_rd),
    .io_rdata(io_rdata), .out_bus(out_bus), .kb_irq(kb_irq)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];          // keys expected in the FIFO, head first
  logic              exp_ovf;
  logic [DATA_W-1:0] exp_out [OUT_CH];
  logic [DATA_W-1:0] exp_in;

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < OUT_CH; k++) exp_out[k] = '0;
    exp_in = '0;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == 0) v = exp_in;
    else if (a == 1) v = (exp_q.size() > 0) ? exp_q[0] : '0;
    else if (a == 2) v = (exp_ovf ? 8'h80 : 8'h00) + DATA_W'(exp_q.size());
    else if (a >= 4 && a < 4 + OUT_CH) v = exp_out[a-4];
    return v;
  endfunction

  function automatic logic [OUT_CH*DATA_W-1:0] model_bus();
    logic [OUT_CH*DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < OUT_CH; k++) b[k*DATA_W +: DATA_W] = exp_out[k];
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input int a, input logic [DATA_W-1:0] d);
    io_addr  = ADDR_W'(a);
    io_wdata = d;
    io_wr    = 1'b1;
    @(negedge clk);
    io_wr    = 1'b0;
    if (a == 2 && d[DATA_W-1]) exp_ovf = 1'b0;
    if (a >= 4 && a < 4 + OUT_CH) exp_out[a-4] = d;
  endtask

  task automatic bus_read(input int a, output logic [DATA_W-1:0] d);
    io_addr = ADDR_W'(a);
    io_rd   = 1'b1;
    @(negedge clk);
    io_rd   = 1'b0;
    d       = io_rdata;
    if (a == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic press_key(input logic [DATA_W-1:0] code);
    KB        = code;
    kb_strobe = 1'b1;
    repeat (4) @(negedge clk);
    kb_strobe = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() < KB_DEPTH) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic set_input(input logic [DATA_W-1:0] v);
    in = v;
    repeat (3) @(negedge clk);
    exp_in = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    exp_in = '0;
    set_input(in);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DATA_W-1:0] d, e;
    bus_write(4, 8'hA5);
    press_key(8'h77);
    bus_read(4, d);
    if (d !== 8'hA5) begin
      errors++; $display("FAIL reset_pre_rd out0 got %h exp %h", d, 8'hA5);
    end
    checks++;
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #3 rst = 1'b0;
    #1;
    if (out_bus !== '0) begin
      errors++; $display("FAIL reset_out_bus got %h exp 0", out_bus);
    end
    checks++;
    if (kb_irq !== 1'b0) begin
      errors++; $display("FAIL reset_kb_irq got %b exp 0", kb_irq);
    end
    checks++;
    if (io_rdata !== '0) begin
      errors++; $display("FAIL reset_io_rdata got %h exp 0", io_rdata);
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_input(in);
    e = model_read(2);
    bus_read(2, d);
    if (d !== e) begin
      errors++; $display("FAIL reset_stat got %h exp %h", d, e);
    end
    checks++;
  endtask

  task automatic test_outputs();
    logic [DATA_W-1:0] d;
    bus_write(4, 8'h12);
    bus_write(5, 8'h34);
    if (out_bus !== 16'h3412) begin
      errors++; $display("FAIL out_bus got %h exp %h", out_bus, 16'h3412);
    end
    checks++;
    bus_read(5, d);
    if (d !== 8'h34) begin
      errors++; $display("FAIL out1_rd got %h exp %h", d, 8'h34);
    end
    checks++;
    // Simultaneous read and write of OUT1: read returns the old value.
    io_addr = 4'h5; io_wdata = 8'hC3; io_wr = 1'b1; io_rd = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    exp_out[1] = 8'hC3;
    if (io_rdata !== 8'h34) begin
      errors++; $display("FAIL rw_same_cycle got %h exp %h", io_rdata, 8'h34);
    end
    checks++;
    if (out_bus !== model_bus()) begin
      errors++; $display("FAIL rw_out_bus got %h exp %h", out_bus, model_bus());
    end
    checks++;
    // io_rdata holds while no read is issued; unmapped write is ignored.
    bus_write(3, 8'hFF);
    bus_write(7, 8'hEE);
    repeat (2) @(negedge clk);
    if (io_rdata !== 8'h34) begin
      errors++; $display("FAIL rdata_hold got %h exp %h", io_rdata, 8'h34);
    end
    checks++;
    bus_read(3, d);
    if (d !== 8'h00) begin
      errors++; $display("FAIL unmapped_rd got %h exp 0", d);
    end
    checks++;
    if (out_bus !== model_bus()) begin
      errors++; $display("FAIL unmapped_wr_bus got %h exp %h", out_bus, model_bus());
    end
    checks++;
  endtask

  task automatic test_input();
    logic [DATA_W-1:0] d;
    set_input(8'h5A);
    bus_read(0, d);
    if (d !== 8'h5A) begin
      errors++; $display("FAIL in_rd got %h exp %h", d, 8'h5A);
    end
    checks++;
  endtask

  task automatic test_keys();
    logic [DATA_W-1:0] d, e;
    press_key(8'h31);
    press_key(8'h32);
    if (kb_irq !== 1'b1) begin
      errors++; $display("FAIL keys_irq got %b exp 1", kb_irq);
    end
    checks++;
    bus_read(2, d);
    if (d !== 8'h02) begin
      errors++; $display("FAIL keys_stat got %h exp %h", d, 8'h02);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      e = model_read(1);
      bus_read(1, d);
      if (d !== e) begin
        errors++; $display("FAIL keys_pop%0d got %h exp %h", i, d, e);
      end
      checks++;
    end
    if (kb_irq !== 1'b0) begin
      errors++; $display("FAIL keys_irq_clr got %b exp 0", kb_irq);
    end
    checks++;
    bus_read(1, d);
    if (d !== 8'h00) begin
      errors++; $display("FAIL empty_pop got %h exp 0", d);
    end
    checks++;
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d, e;
    for (int i = 0; i < 5; i++) press_key(DATA_W'($urandom_range(1, 255)));
    bus_read(2, d);
    if (d !== 8'h84) begin
      errors++; $display("FAIL ovf_stat got %h exp %h", d, 8'h84);
    end
    checks++;
    bus_write(2, 8'h7F);   // MSB clear: overflow stays
    e = model_read(2);
    bus_read(2, d);
    if (d !== e) begin
      errors++; $display("FAIL ovf_keep got %h exp %h", d, e);
    end
    checks++;
    bus_write(2, 8'h80);
    bus_read(2, d);
    if (d !== 8'h04) begin
      errors++; $display("FAIL ovf_clr got %h exp %h", d, 8'h04);
    end
    checks++;
    for (int i = 0; i < KB_DEPTH; i++) begin
      e = model_read(1);
      bus_read(1, d);
      if (d !== e) begin
        errors++; $display("FAIL ovf_order%0d got %h exp %h", i, d, e);
      end
      checks++;
    end
  endtask

  task automatic test_full_pop_push();
    logic [DATA_W-1:0] d, e, k;
    for (int i = 0; i < KB_DEPTH; i++) press_key(8'h40 + DATA_W'(i));
    k = 8'h99;
    KB = k;
    kb_strobe = 1'b1;
    repeat (2) @(negedge clk);
    // The key is captured on the next edge; pop on that same edge.
    e = model_read(1);
    bus_read(1, d);
    exp_q.push_back(k);
    kb_strobe = 1'b0;
    repeat (4) @(negedge clk);
    if (d !== e) begin
      errors++; $display("FAIL simul_head got %h exp %h", d, e);
    end
    checks++;
    bus_read(2, d);
    if (d !== 8'h04) begin
      errors++; $display("FAIL simul_stat got %h exp %h", d, 8'h04);
    end
    checks++;
    for (int i = 0; i < KB_DEPTH; i++) begin
      e = model_read(1);
      bus_read(1, d);
      if (d !== e) begin
        errors++; $display("FAIL simul_order%0d got %h exp %h", i, d, e);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d, e;
    int a;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: bus_write($urandom_range(0, 15), DATA_W'($urandom));
        1: begin
          a = $urandom_range(0, 15);
          e = model_read(a);
          bus_read(a, d);
          if (d !== e) begin
            errors++; $display("FAIL rand_rd it%0d addr %0d got %h exp %h", it, a, d, e);
          end
          checks++;
        end
        2: press_key(DATA_W'($urandom));
        3: bus_write(2, {1'b1, 7'($urandom)});
        default: set_input(DATA_W'($urandom));
      endcase
      if (kb_irq !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_irq it%0d got %b exp %b", it, kb_irq, exp_q.size() != 0);
      end
      checks++;
      if (out_bus !== model_bus()) begin
        errors++; $display("FAIL rand_bus it%0d got %h exp %h", it, out_bus, model_bus());
      end
      checks++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    do_reset();
    test_reset();
    test_outputs();
    test_input();
    test_keys();
    test_overflow();
    test_full_pop_push();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
